div_unit: RTL and testbench

Multicycle integer divider in the execute stage of the 5-stage MIPS pipeline, serving DIV and DIVU. It runs a radix-2 restoring division over a fixed number of cycles and writes the quotient to LO and the remainder to HI. While busy it drives `stall_divE`, which the hazard unit uses to freeze F, D and E until the result is ready.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_if.sv | 34 +++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 109 ++++++++++
 tb/tb_div_unit.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the multicycle divider.
//   div_state_e : FSM encoding (IDLE, BUSY, DONE)
//   DIV_WIDTH   : default operand/result width
//   DIV0_QUO    : quotient produced by a divide by zero (all ones)
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // A restoring divider with a zero divisor subtracts nothing, so every
    // quotient bit is set and the remainder is the dividend itself.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/div_if.sv
// div_if: execute-stage request/response bundle for the divider.
//   master (execute stage / hazard unit side):
//     drives div_startE, signedE, srcaE, srcbE, cancelE
//     reads  stall_divE, div_readyE, hi_div, lo_div
//   slave (div_unit): the mirror image.
//
// Handshake: div_startE is held by the pipeline while the DIV/DIVU sits in E.
// The divider accepts it only in IDLE and answers with stall_divE until the
// result exists; div_readyE is a one-cycle pulse during which hi_div/lo_div
// are valid and the instruction leaves E. cancelE aborts any accepted request
// and blocks acceptance of a new one in the same cycle.
import div_pkg::*;

interface div_if #(parameter int WIDTH = DIV_WIDTH);
    logic             div_startE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancelE;
    logic             stall_divE;
    logic             div_readyE;
    logic [WIDTH-1:0] hi_div;
    logic [WIDTH-1:0] lo_div;

    modport master (
        output div_startE, signedE, srcaE, srcbE, cancelE,
        input  stall_divE, div_readyE, hi_div, lo_div
    );

    modport slave (
        input  div_startE, signedE, srcaE, srcbE, cancelE,
        output stall_divE, div_readyE, hi_div, lo_div
    );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem, quo    in  current partial remainder / quotient-dividend register
//   divisor     in  divisor magnitude
//   rem_next    out remainder after this iteration
//   quo_next    out quotient register after this iteration (new bit in LSB)
import div_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // Shifting {rem,quo} left brings the next dividend bit into rem. The
    // extra top bit keeps 2*rem+1 exact when rem is close to 2^WIDTH.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign fits     = ~diff[WIDTH];
    assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};
endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle DIV/DIVU unit in the execute stage.
//   clk, rst   pipeline clock, synchronous active-high reset
//   bus        div_if.slave: start/sign/operands/cancel in,
//              stall_divE, div_readyE, hi_div (remainder), lo_div (quotient) out
//   dbg_state  current FSM state
// A start in cycle 0 stalls cycles 0..WIDTH and pulses div_readyE in cycle
// WIDTH+1. Signed operands are divided as magnitudes and fixed up at the end.
import div_pkg::*;

module div_unit #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    div_if.slave       bus,
    output div_state_e dbg_state
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, divisor;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             qsign, rsign, div0, ready_q;
    logic             start;

    // Cancel wins over start, so a flushed instruction never begins.
    assign start = (state == S_IDLE) && bus.div_startE && !bus.cancelE;

    // The most negative value keeps its bit pattern, which is its correct
    // magnitude when read as unsigned.
    assign abs_a = (bus.signedE && bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
    assign abs_b = (bus.signedE && bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            qsign   <= 1'b0;
            rsign   <= 1'b0;
            div0    <= 1'b0;
            ready_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_BUSY;
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= abs_a;
                        divisor <= abs_b;
                        qsign   <= bus.signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
                        rsign   <= bus.signedE & bus.srcaE[WIDTH-1];
                        div0    <= ~|bus.srcbE;
                    end
                end
                S_BUSY: begin
                    if (bus.cancelE) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state   <= S_DONE;
                            ready_q <= 1'b1;
                            // A zero divisor keeps the raw all-ones quotient;
                            // the remainder fix-up restores the signed dividend.
                            lo_q    <= div0  ? DIV0_QUO[WIDTH-1:0]
                                     : qsign ? -quo_nx : quo_nx;
                            hi_q    <= rsign ? -rem_nx : rem_nx;
                        end
                    end
                end
                S_DONE: begin
                    // Leave unconditionally so a still-high start cannot
                    // retrigger the instruction that just completed.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall_divE = (state == S_BUSY) || start;
    assign bus.div_readyE = ready_q && !bus.cancelE;
    assign bus.hi_div     = hi_q;
    assign bus.lo_div     = lo_q;
    assign dbg_state      = state;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit with a cycle-level reference model.
import div_pkg::*;

module tb_div_unit;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    div_state_e dbg_state;

    div_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Arithmetic result of DIV/DIVU from the architectural rules.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Timeline: m_age = cycles since the accepted start (0 = nothing in flight).
    int          m_age = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [63:0] m_res = '0;
    logic [31:0] m_exp_q[$];
    logic        e_stall, e_ready;

    always @(negedge clk) begin
        if (check_en) begin
            e_stall = (m_age == 0 && bus.div_startE && !bus.cancelE) || (m_age >= 1 && m_age <= W);
            e_ready = (m_age == W + 1) && !bus.cancelE;
            chk("cyc_stall", 32'(bus.stall_divE), 32'(e_stall));
            chk("cyc_ready", 32'(bus.div_readyE), 32'(e_ready));
            chk("cyc_hi", bus.hi_div, m_hi);
            chk("cyc_lo", bus.lo_div, m_lo);
            if (rst) begin
                m_age = 0;
                m_hi  = '0;
                m_lo  = '0;
            end else if (m_age == 0) begin
                if (bus.div_startE && !bus.cancelE) begin
                    m_age = 1;
                    m_res = model(bus.srcaE, bus.srcbE, bus.signedE);
                end
            end else if (m_age <= W) begin
                if (bus.cancelE) begin
                    m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == W + 1) {m_hi, m_lo} = m_res;
                end
            end else begin
                m_age = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.div_startE = 1'b0;
        bus.signedE    = 1'b0;
        bus.cancelE    = 1'b0;
        bus.srcaE      = '0;
        bus.srcbE      = '0;
    endtask

    // Start one operation, scramble the operands while busy, and check the
    // result against hand-computed literals and the 33-cycle ready latency.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] elo, input logic [31:0] ehi, input string name);
        int n;
        @(posedge clk); #1;
        bus.div_startE = 1'b1;
        bus.srcaE = a;
        bus.srcbE = b;
        bus.signedE = s;
        m_exp_q.push_back(elo);
        m_exp_q.push_back(ehi);
        @(posedge clk); #1;
        bus.div_startE = 1'b0;
        bus.srcaE = $urandom;
        bus.srcbE = $urandom;
        bus.signedE = 1'($urandom_range(0, 1));
        n = 1;
        while (!bus.div_readyE && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(W + 1));
        chk({name, "_lo"}, bus.lo_div, m_exp_q.pop_front());
        chk({name, "_hi"}, bus.hi_div, m_exp_q.pop_front());
    endtask

    int pulses;

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(bus.stall_divE), 32'd0);
        chk("rst_ready", 32'(bus.div_readyE), 32'd0);
        chk("rst_hi", bus.hi_div, 32'd0);
        chk("rst_lo", bus.lo_div, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // Main arithmetic, literal expectations.
        run_div(32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          "divu_100_7");
        run_div(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  "div_m7_2");
        run_div(32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          "div_7_m2");
        run_div(32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  "div_m100_m7");
        run_div(32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  "divu_by0");
        run_div(32'hFFFF_FFFB,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  "div_by0");
        run_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          "div_min_m1");
        run_div(32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          "divu_max_1");
        run_div(32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, 32'd1,          32'd1,          "divu_max_maxm1");
        run_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  "divu_min_max");
        run_div(32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0,          "div_min_2");

        // Cancel while busy: stall drops next cycle, outputs hold, then a clean restart.
        @(posedge clk); #1;
        bus.div_startE = 1'b1;
        bus.srcaE = 32'd1000;
        bus.srcbE = 32'd3;
        bus.signedE = 1'b0;
        @(posedge clk); #1;
        bus.div_startE = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.cancelE = 1'b1;
        @(posedge clk); #1;
        bus.cancelE = 1'b0;
        #1;
        chk("cancel_stall", 32'(bus.stall_divE), 32'd0);
        chk("cancel_ready", 32'(bus.div_readyE), 32'd0);
        chk("cancel_lo_hold", bus.lo_div, 32'hC000_0000);
        chk("cancel_hi_hold", bus.hi_div, 32'd0);
        run_div(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, "after_cancel");

        // Cancel in IDLE blocks the start.
        @(posedge clk); #1;
        bus.div_startE = 1'b1;
        bus.cancelE = 1'b1;
        #1;
        chk("idle_cancel_stall", 32'(bus.stall_divE), 32'd0);
        @(posedge clk); #1;
        bus.div_startE = 1'b0;
        bus.cancelE = 1'b0;
        #1;
        chk("idle_cancel_state", 32'(dbg_state), 32'(S_IDLE));

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        bus.div_startE = 1'b1;
        bus.srcaE = 32'd999;
        bus.srcbE = 32'd10;
        @(posedge clk); #1;
        bus.div_startE = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_stall", 32'(bus.stall_divE), 32'd0);
        chk("midrst_ready", 32'(bus.div_readyE), 32'd0);
        chk("midrst_hi", bus.hi_div, 32'd0);
        chk("midrst_lo", bus.lo_div, 32'd0);

        // Start held through DONE: one pulse, then released in IDLE.
        @(posedge clk); #1;
        bus.div_startE = 1'b1;
        bus.srcaE = 32'd77;
        bus.srcbE = 32'd8;
        bus.signedE = 1'b0;
        pulses = 0;
        for (int c = 0; c < W + 2; c++) begin
            #1;
            if (bus.div_readyE) pulses++;
            @(posedge clk); #1;
        end
        bus.div_startE = 1'b0;
        #1;
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_release_stall", 32'(bus.stall_divE), 32'd0);
        chk("held_lo", bus.lo_div, 32'd9);
        chk("held_hi", bus.hi_div, 32'd5);

        // Start held into IDLE after DONE: a fresh operation begins.
        @(posedge clk); #1;
        bus.div_startE = 1'b1;
        for (int c = 0; c < W + 2; c++) begin
            @(posedge clk); #1;
        end
        #1;
        chk("held_restart_stall", 32'(bus.stall_divE), 32'd1);
        @(posedge clk); #1;
        bus.div_startE = 1'b0;
        bus.cancelE = 1'b1;
        @(posedge clk); #1;
        bus.cancelE = 1'b0;
        #1;
        chk("restart_cancel_stall", 32'(bus.stall_divE), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
